tx_stream_arbiter: RTL and testbench
====================================

# tx_stream_arbiter

Packet-level round-robin arbiter that shares the single UART transmit byte path between two byte-stream requesters: the manta response stream and a second on-chip source such as a status reporter. It sits between the requesters and the UART transmitter, in front of `rs232_tx_ttl`. Once a requester is granted, it holds the path until it completes a packet. An idle watchdog reclaims a grant from a requester that stalls mid-packet.

## Interface
Parameters:
- `IDLE_TIMEOUT`, default 1024: number of consecutive granted cycles with no byte offered before the grant is revoked.
- `TIMEOUT_W`, default 11: counter width. Must satisfy 2^TIMEOUT_W > IDLE_TIMEOUT.

Ports:
- `clk`  in  1: system clock. This is the single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `req0_data`  in  8: byte from requester 0 (manta).
- `req0_valid`  in  1: requester 0 is offering a byte.
- `req0_last`  in  1: the offered byte is the last byte of the packet.
- `req0_ready`  out  1: the byte from requester 0 is accepted this cycle.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same as requester 0, for requester 1.
- `tx_data`  out  8: byte sent to the UART transmitter.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: the UART transmitter accepts the byte.
- `grant`  out  2: one-hot grant, 00 when idle. Provided for debug and observation.
- `timeout_pulse`  out  1: single-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - If exactly one `reqN_valid` is high, go to GRANTN.
  - If both are high, grant the requester that is not `last_winner`.
  - `last_winner` resets to 1, so requester 0 wins the first tie.
- In GRANTN, the datapath is combinational pass-through:
  - `tx_data = reqN_data`
  - `tx_valid = reqN_valid`
  - `reqN_ready = tx_ready`
  - The other requester's ready is held at 0.
- A transfer occurs when `reqN_valid & tx_ready`.
- A transfer with `reqN_last = 1` ends the packet. On the next edge: go to IDLE, set `last_winner <= N`, clear the watchdog.
- Watchdog, active in GRANT states only:
  - The counter clears on every transfer and on every state entry.
  - It increments on each cycle where `reqN_valid = 0`.
  - A cycle with valid high but `tx_ready` low does not count; backpressure is not a stall.
  - When the counter equals IDLE_TIMEOUT-1 and valid is still low: go to IDLE, set `last_winner <= N`, pulse `timeout_pulse` for one cycle.
- Partial packets are not flushed or padded. The downstream protocol layer handles framing recovery.
- Outputs in IDLE: `tx_valid = 0`, `tx_data = 0`, both readies 0, `grant = 00`.
- Reset values: state IDLE, counter 0, `last_winner` 1, `timeout_pulse` 0, all handshake outputs 0.
- Reset mid-packet abandons the packet. The requester must tolerate a dropped tail.

## Timing
- Grant latency: 1 cycle from `reqN_valid` rising in IDLE to GRANTN. The first byte can transfer in that GRANT cycle.
- Arbitration bubble: 1 IDLE cycle between consecutive packets, including back-to-back packets from the same requester.
- Data path: zero-latency pass-through with no registering of `tx_data` or `tx_valid`.
- Simultaneous `last` transfer and `rst`: reset wins.
- Watchdog: it expires exactly IDLE_TIMEOUT stalled cycles after the last transfer or the grant. `timeout_pulse` is asserted on the first IDLE cycle.
- Fairness: with both requesters continuously valid, packets alternate strictly 0,1,0,1…

## Structure
- Package `tx_arb_pkg` holds:
  - the `state_t` enum (IDLE, GRANT0, GRANT1);
  - localparams `N_REQ = 2` and `BYTE_W = 8`.
- No sub-modules. The datapath mux and FSM fit in one module.
- The watchdog counter stays inline. It is not split out.

## Test plan
- Single packet: requester 0 sends 0x4D 0x31 0x0A with `last` on 0x0A, `tx_ready` held high. Required: `grant` = 01 for 3 cycles, `tx_data` sequence matches, then `grant` = 00 for one cycle.
- Tie after reset: both requesters valid in the same cycle. Required: requester 0 is granted first. After its `last`, requester 1 is granted after a 1-cycle IDLE, and `req1_ready` was 0 throughout requester 0's packet.
- Backpressure: `tx_ready` toggles 1,0,0,1 during a 4-byte packet. Required: no byte dropped or duplicated, and the watchdog never fires.
- Stall timeout: IDLE_TIMEOUT = 8; requester 1 sends 1 byte without `last`, then drops valid. Required: `timeout_pulse` asserts 8 cycles after that transfer and `grant` returns to 00. Requester 0, already waiting, is granted on the next cycle.
- Reset mid-packet: assert `rst` for 1 cycle after the 2nd byte of a packet. Required: next cycle has state IDLE, `tx_valid` = 0, `grant` = 00, and `last_winner` = 1.
- Fairness soak: both requesters stream 2-byte packets for 100 packets. Required: grants alternate exactly and the byte count per requester is 100.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Latency: none, this package holds declarations only.
// Backpressure: none, this package holds declarations only.
package tx_arb_pkg;

    localparam int N_REQ  = 2;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

endpackage

// File: rtl/tx_stream_arbiter.sv
// Packet-level round-robin arbiter that shares one UART byte path between two
// requesters. Latency: 1-cycle grant, then zero-latency pass-through.
// Backpressure: tx_ready goes straight to the granted ready; the other ready stays 0.
module tx_stream_arbiter
    import tx_arb_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TIMEOUT_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] req0_data,
    input  logic              req0_valid,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic [BYTE_W-1:0] req1_data,
    input  logic              req1_valid,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [N_REQ-1:0]  grant,
    output logic              timeout_pulse
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(IDLE_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

    state_t               state;
    state_t               state_nxt;
    logic                 last_winner;
    logic                 last_winner_nxt;
    logic [TIMEOUT_W-1:0] cnt;
    logic [TIMEOUT_W-1:0] cnt_nxt;
    logic                 timeout_nxt;
    logic                 sel_valid;
    logic                 sel_last;

    // State, round-robin pointer, watchdog counter and the revoke pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_winner   <= 1'b1;
            cnt           <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_winner   <= last_winner_nxt;
            cnt           <= cnt_nxt;
            timeout_pulse <= timeout_nxt;
        end
    end

    // Arbitration, pass-through mux and watchdog next-state.
    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        cnt_nxt         = cnt;
        timeout_nxt     = 1'b0;
        tx_data         = '0;
        tx_valid        = 1'b0;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        grant           = 2'b00;
        sel_valid       = 1'b0;
        sel_last        = 1'b0;

        case (state)
            IDLE: begin
                // Entering a grant always starts the watchdog from zero.
                cnt_nxt = '0;
                if (req0_valid && req1_valid) begin
                    state_nxt = last_winner ? GRANT0 : GRANT1;
                end else if (req0_valid) begin
                    state_nxt = GRANT0;
                end else if (req1_valid) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                tx_data    = req0_data;
                tx_valid   = req0_valid;
                req0_ready = tx_ready;
                grant      = 2'b01;
                sel_valid  = req0_valid;
                sel_last   = req0_last;
            end
            GRANT1: begin
                tx_data    = req1_data;
                tx_valid   = req1_valid;
                req1_ready = tx_ready;
                grant      = 2'b10;
                sel_valid  = req1_valid;
                sel_last   = req1_last;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state == GRANT0 || state == GRANT1) begin
            if (sel_valid && tx_ready) begin
                cnt_nxt = '0;
                if (sel_last) begin
                    state_nxt       = IDLE;
                    last_winner_nxt = (state == GRANT1);
                end
            end else if (!sel_valid) begin
                // Only a silent requester counts as stalled; valid with
                // tx_ready low is ordinary backpressure and holds the count.
                if (cnt == CNT_MAX) begin
                    state_nxt       = IDLE;
                    last_winner_nxt = (state == GRANT1);
                    cnt_nxt         = '0;
                    timeout_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Directed bench for tx_stream_arbiter with a short watchdog (IDLE_TIMEOUT = 8).
// Latency: inputs driven 1 ns after posedge, outputs sampled on negedge.
// Backpressure: tx_ready is driven directly by the stimulus sequence.
module tb_tx_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] r0d, r1d;
    logic       r0v, r0l, r1v, r1l;
    logic       rdy0, rdy1;
    logic [7:0] txd;
    logic       txv, txr;
    logic [1:0] gnt;
    logic       tpulse;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tx_stream_arbiter #(
        .IDLE_TIMEOUT (8),
        .TIMEOUT_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_data     (r0d),
        .req0_valid    (r0v),
        .req0_last     (r0l),
        .req0_ready    (rdy0),
        .req1_data     (r1d),
        .req1_valid    (r1v),
        .req1_last     (r1l),
        .req1_ready    (rdy1),
        .tx_data       (txd),
        .tx_valid      (txv),
        .tx_ready      (txr),
        .grant         (gnt),
        .timeout_pulse (tpulse)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] pkt1 [3];
        logic [7:0] e;
        logic       txr_k;
        logic       b0, b1;
        int         nx, p0, p1, n0, n1, who;

        pkt1[0] = 8'h4D; pkt1[1] = 8'h31; pkt1[2] = 8'h0A;

        // Reset
        rst = 1'b1; txr = 1'b0;
        r0v = 1'b0; r0d = 8'h00; r0l = 1'b0;
        r1v = 1'b0; r1d = 8'h00; r1l = 1'b0;
        repeat (2) cyc();
        smp();
        chk("rst_grant", 8'(gnt), 8'h00);
        chk("rst_tx_valid", 8'(txv), 8'h00);
        chk("rst_tx_data", txd, 8'h00);
        chk("rst_ready0", 8'(rdy0), 8'h00);
        chk("rst_ready1", 8'(rdy1), 8'h00);
        chk("rst_timeout", 8'(tpulse), 8'h00);
        cyc(); rst = 1'b0;

        // Single packet 4D 31 0A from requester 0
        cyc(); txr = 1'b1; r0v = 1'b1; r0d = 8'h4D; r0l = 1'b0;
        smp();
        chk("t1_idle_grant", 8'(gnt), 8'h00);
        chk("t1_idle_ready0", 8'(rdy0), 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(); r0d = pkt1[i]; r0l = (i == 2);
            smp();
            chk("t1_grant", 8'(gnt), 8'h01);
            chk("t1_data", txd, pkt1[i]);
            chk("t1_valid", 8'(txv), 8'h01);
            chk("t1_ready0", 8'(rdy0), 8'h01);
        end
        cyc(); r0v = 1'b0; r0l = 1'b0;
        smp();
        chk("t1_bubble_grant", 8'(gnt), 8'h00);
        chk("t1_bubble_valid", 8'(txv), 8'h00);
        chk("t1_bubble_data", txd, 8'h00);

        // Reset, then a tie: requester 0 must win first
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        r0v = 1'b1; r0d = 8'hA0; r0l = 1'b0;
        r1v = 1'b1; r1d = 8'hB0; r1l = 1'b1;
        smp();
        chk("t2_idle_grant", 8'(gnt), 8'h00);
        cyc(); smp();
        chk("t2_g0_grant", 8'(gnt), 8'h01);
        chk("t2_g0_data", txd, 8'hA0);
        chk("t2_g0_ready1", 8'(rdy1), 8'h00);
        cyc(); r0d = 8'hA1; r0l = 1'b1;
        smp();
        chk("t2_g0_grant_b", 8'(gnt), 8'h01);
        chk("t2_g0_data_b", txd, 8'hA1);
        chk("t2_g0_ready1_b", 8'(rdy1), 8'h00);
        cyc(); r0v = 1'b0; r0l = 1'b0;
        smp();
        chk("t2_bubble_grant", 8'(gnt), 8'h00);
        chk("t2_bubble_ready1", 8'(rdy1), 8'h00);
        cyc(); smp();
        chk("t2_g1_grant", 8'(gnt), 8'h02);
        chk("t2_g1_data", txd, 8'hB0);
        chk("t2_g1_ready1", 8'(rdy1), 8'h01);
        chk("t2_g1_ready0", 8'(rdy0), 8'h00);
        cyc(); r1v = 1'b0; r1l = 1'b0;
        smp();
        chk("t2_end_grant", 8'(gnt), 8'h00);

        // Backpressure: tx_ready low for 10 cycles mid-packet, 4 bytes C0..C3
        cyc(); r0v = 1'b1; r0d = 8'hC0; r0l = 1'b0; txr = 1'b0;
        smp();
        chk("t3_idle_grant", 8'(gnt), 8'h00);
        nx = 0;
        for (int k = 0; k < 14; k++) begin
            txr_k = (k == 0) || (k >= 11);
            e = (k == 0) ? 8'hC0 : (k <= 11) ? 8'hC1 : (k == 12) ? 8'hC2 : 8'hC3;
            cyc(); txr = txr_k; r0d = e; r0l = (k == 13);
            smp();
            chk("t3_grant", 8'(gnt), 8'h01);
            chk("t3_data", txd, e);
            chk("t3_ready0", 8'(rdy0), 8'(txr_k));
            chk("t3_timeout", 8'(tpulse), 8'h00);
            if (rdy0 && txv) nx++;
        end
        cyc(); r0v = 1'b0; r0l = 1'b0; txr = 1'b1;
        smp();
        chk("t3_end_grant", 8'(gnt), 8'h00);
        chk("t3_end_timeout", 8'(tpulse), 8'h00);
        chk("t3_transfers", 8'(nx), 8'd4);

        // Stall timeout: requester 1 sends one byte then goes silent
        cyc(); r1v = 1'b1; r1d = 8'hD0; r1l = 1'b0;
        r0v = 1'b1; r0d = 8'hE0; r0l = 1'b0;
        smp();
        chk("t4_idle_grant", 8'(gnt), 8'h00);
        cyc(); smp();
        chk("t4_g1_grant", 8'(gnt), 8'h02);
        chk("t4_g1_data", txd, 8'hD0);
        chk("t4_g1_ready0", 8'(rdy0), 8'h00);
        for (int s = 1; s <= 8; s++) begin
            cyc(); r1v = 1'b0;
            smp();
            chk("t4_stall_grant", 8'(gnt), 8'h02);
            chk("t4_stall_timeout", 8'(tpulse), 8'h00);
        end
        cyc(); r0l = 1'b1;
        smp();
        chk("t4_revoke_grant", 8'(gnt), 8'h00);
        chk("t4_revoke_pulse", 8'(tpulse), 8'h01);
        cyc(); smp();
        chk("t4_g0_grant", 8'(gnt), 8'h01);
        chk("t4_g0_pulse", 8'(tpulse), 8'h00);
        chk("t4_g0_data", txd, 8'hE0);
        cyc(); r0v = 1'b0; r0l = 1'b0;
        smp();
        chk("t4_end_grant", 8'(gnt), 8'h00);

        // Reset after the 2nd byte of a requester-1 packet
        cyc(); r1v = 1'b1; r1d = 8'hF0; r1l = 1'b0;
        smp();
        chk("t5_idle_grant", 8'(gnt), 8'h00);
        cyc(); smp();
        chk("t5_b0_grant", 8'(gnt), 8'h02);
        chk("t5_b0_data", txd, 8'hF0);
        cyc(); r1d = 8'hF1;
        smp();
        chk("t5_b1_data", txd, 8'hF1);
        cyc(); rst = 1'b1; r1d = 8'hF2; r0v = 1'b1; r0d = 8'hE1; r0l = 1'b1;
        cyc(); rst = 1'b0;
        smp();
        chk("t5_post_grant", 8'(gnt), 8'h00);
        chk("t5_post_valid", 8'(txv), 8'h00);
        chk("t5_post_ready1", 8'(rdy1), 8'h00);
        chk("t5_post_timeout", 8'(tpulse), 8'h00);
        cyc(); smp();
        chk("t5_tie_winner", 8'(gnt), 8'h01);
        chk("t5_tie_data", txd, 8'hE1);
        cyc(); r0v = 1'b0; r0l = 1'b0; r1v = 1'b0;
        smp();
        chk("t5_end_grant", 8'(gnt), 8'h00);

        // Fairness soak: 100 two-byte packets, both requesters always valid
        b0 = 1'b0; b1 = 1'b0; p0 = 0; p1 = 0; n0 = 0; n1 = 0;
        for (int pkt = 0; pkt < 100; pkt++) begin
            who = (pkt % 2 == 0) ? 1 : 0;
            for (int c = 0; c < 3; c++) begin
                cyc();
                r0v = 1'b1; r0d = {1'b0, p0[5:0], b0}; r0l = b0;
                r1v = 1'b1; r1d = {1'b1, p1[5:0], b1}; r1l = b1;
                smp();
                if (c == 0) begin
                    chk("t6_bubble", 8'(gnt), 8'h00);
                end else begin
                    e = {who[0], 6'(pkt / 2), (c == 2)};
                    chk("t6_grant", 8'(gnt), (who == 1) ? 8'h02 : 8'h01);
                    chk("t6_data", txd, e);
                end
                if (rdy0 && r0v) begin
                    n0++;
                    if (b0) p0++;
                    b0 = ~b0;
                end
                if (rdy1 && r1v) begin
                    n1++;
                    if (b1) p1++;
                    b1 = ~b1;
                end
            end
        end
        cyc(); r0v = 1'b0; r1v = 1'b0; r0l = 1'b0; r1l = 1'b0;
        smp();
        chk("t6_bytes0", 8'(n0), 8'd100);
        chk("t6_bytes1", 8'(n1), 8'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
